// File: rtl/expl_axi_sram.sv
`timescale 1ns/1ps
// Single-ported word SRAM terminating the E203 expl AXI port; one transaction at a time,
// FIXED/INCR/WRAP bursts, byte strobes, SLVERR on out-of-range beats or malformed bursts.
module expl_axi_sram #(
  parameter int unsigned              ADDR_W      = 32,
  parameter logic [ADDR_W-1:0]        BASE_ADDR   = 'h4000_0000,
  parameter int unsigned              DEPTH_WORDS = 4096
) (
  input  logic              clk_16M,
  input  logic              ck_rst,
  input  logic              expl_axi_arvalid,
  output logic              expl_axi_arready,
  input  logic [ADDR_W-1:0] expl_axi_araddr,
  input  logic [3:0]        expl_axi_arcache,
  input  logic [2:0]        expl_axi_arprot,
  input  logic [1:0]        expl_axi_arlock,
  input  logic [1:0]        expl_axi_arburst,
  input  logic [3:0]        expl_axi_arlen,
  input  logic [2:0]        expl_axi_arsize,
  input  logic              expl_axi_awvalid,
  output logic              expl_axi_awready,
  input  logic [ADDR_W-1:0] expl_axi_awaddr,
  input  logic [3:0]        expl_axi_awcache,
  input  logic [2:0]        expl_axi_awprot,
  input  logic [1:0]        expl_axi_awlock,
  input  logic [1:0]        expl_axi_awburst,
  input  logic [3:0]        expl_axi_awlen,
  input  logic [2:0]        expl_axi_awsize,
  input  logic              expl_axi_wvalid,
  output logic              expl_axi_wready,
  input  logic [31:0]       expl_axi_wdata,
  input  logic [3:0]        expl_axi_wstrb,
  input  logic              expl_axi_wlast,
  output logic              expl_axi_bvalid,
  input  logic              expl_axi_bready,
  output logic [1:0]        expl_axi_bresp,
  output logic              expl_axi_rvalid,
  input  logic              expl_axi_rready,
  output logic [31:0]       expl_axi_rdata,
  output logic [1:0]        expl_axi_rresp,
  output logic              expl_axi_rlast
);
  localparam int unsigned       IDX_W  = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W-1:0] SPAN   = ADDR_W'(4 * DEPTH_WORDS);
  localparam logic [1:0]        OKAY   = 2'b00;
  localparam logic [1:0]        SLVERR = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_WDATA, S_WRESP, S_RDATA} state_t;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (a >= BASE_ADDR) && ((a - BASE_ADDR) < SPAN);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> 2);
  endfunction

  function automatic logic burst_bad(input logic [1:0] burst, input logic [3:0] len);
    case (burst)
      2'b00, 2'b01: return 1'b0;
      2'b10:        return !(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15);
      default:      return 1'b1;
    endcase
  endfunction

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a, input logic [1:0] burst,
                                                  input logic [3:0] len, input logic [2:0] size);
    logic [ADDR_W-1:0] inc;
    logic [ADDR_W-1:0] mask;
    inc  = a + (ADDR_W'(1) << size);
    mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
    if (burst == 2'b00)                              return a;
    else if (burst == 2'b10 && !burst_bad(burst, len)) return (a & ~mask) | (inc & mask);
    else                                             return inc;
  endfunction

  state_t            r_state, w_state_nxt;
  logic              r_prio_w;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_burst;
  logic [3:0]        r_len, r_cnt;
  logic [2:0]        r_size;
  logic              r_err;
  logic [31:0]       r_rdata;
  logic [1:0]        r_rresp;
  logic [31:0]       r_mem [DEPTH_WORDS];

  logic              w_aw_hs, w_ar_hs, w_w_hs, w_r_hs, w_last, w_beat_ok;
  logic [ADDR_W-1:0] w_nxt_addr, w_ld_addr;
  logic              w_ld_bad, w_ld_in;
  logic [31:0]       w_ld_dat;
  logic [1:0]        w_ld_resp;
  logic              w_unused_ok;

  assign w_unused_ok = ^{expl_axi_arcache, expl_axi_arprot, expl_axi_arlock,
                         expl_axi_awcache, expl_axi_awprot, expl_axi_awlock};

  // Priority flag breaks ties only; a lone valid is always granted.
  assign w_aw_hs = (r_state == S_IDLE) && expl_axi_awvalid && (!expl_axi_arvalid || r_prio_w);
  assign w_ar_hs = (r_state == S_IDLE) && expl_axi_arvalid && (!expl_axi_awvalid || !r_prio_w);
  assign w_w_hs  = (r_state == S_WDATA) && expl_axi_wvalid;
  assign w_r_hs  = (r_state == S_RDATA) && expl_axi_rready;
  assign w_last  = (r_cnt == r_len);

  assign w_nxt_addr = next_addr(r_addr, r_burst, r_len, r_size);
  assign w_beat_ok  = in_range(r_addr);

  // Read data is fetched one beat ahead so rvalid never bubbles under continuous rready.
  assign w_ld_addr = w_ar_hs ? expl_axi_araddr : w_nxt_addr;
  assign w_ld_bad  = w_ar_hs ? burst_bad(expl_axi_arburst, expl_axi_arlen) : r_err;
  assign w_ld_in   = in_range(w_ld_addr);
  assign w_ld_dat  = w_ld_in ? r_mem[word_idx(w_ld_addr)] : 32'd0;
  assign w_ld_resp = (w_ld_bad || !w_ld_in) ? SLVERR : OKAY;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_aw_hs) w_state_nxt = S_WDATA;
               else if (w_ar_hs) w_state_nxt = S_RDATA;
      S_WDATA: if (w_w_hs && w_last) w_state_nxt = S_WRESP;
      S_WRESP: if (expl_axi_bready) w_state_nxt = S_IDLE;
      S_RDATA: if (w_r_hs && w_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign expl_axi_awready = w_aw_hs;
  assign expl_axi_arready = w_ar_hs;
  assign expl_axi_wready  = (r_state == S_WDATA);
  assign expl_axi_bvalid  = (r_state == S_WRESP);
  assign expl_axi_bresp   = ((r_state == S_WRESP) && r_err) ? SLVERR : OKAY;
  assign expl_axi_rvalid  = (r_state == S_RDATA);
  assign expl_axi_rlast   = (r_state == S_RDATA) && w_last;
  assign expl_axi_rdata   = r_rdata;
  assign expl_axi_rresp   = r_rresp;

  always_ff @(posedge clk_16M or negedge ck_rst) begin
    if (!ck_rst) begin
      r_state  <= S_IDLE;
      r_prio_w <= 1'b1;
      r_addr   <= '0;
      r_burst  <= '0;
      r_len    <= '0;
      r_size   <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= OKAY;
    end else begin
      r_state <= w_state_nxt;
      if (w_aw_hs || w_ar_hs) begin
        r_prio_w <= ~r_prio_w;
        r_addr   <= w_aw_hs ? expl_axi_awaddr  : expl_axi_araddr;
        r_burst  <= w_aw_hs ? expl_axi_awburst : expl_axi_arburst;
        r_len    <= w_aw_hs ? expl_axi_awlen   : expl_axi_arlen;
        r_size   <= w_aw_hs ? expl_axi_awsize  : expl_axi_arsize;
        r_cnt    <= '0;
        r_err    <= w_aw_hs ? burst_bad(expl_axi_awburst, expl_axi_awlen) : w_ld_bad;
      end
      if (w_ar_hs) begin
        r_rdata <= w_ld_dat;
        r_rresp <= w_ld_resp;
      end
      // Write errors accumulate into the flag because B reports the whole burst.
      if (w_w_hs) begin
        r_addr <= w_nxt_addr;
        r_cnt  <= r_cnt + 4'd1;
        r_err  <= r_err | !w_beat_ok | (expl_axi_wlast != w_last);
      end
      if (w_r_hs) begin
        if (w_last) begin
          r_rdata <= '0;
          r_rresp <= OKAY;
        end else begin
          r_addr  <= w_nxt_addr;
          r_cnt   <= r_cnt + 4'd1;
          r_rdata <= w_ld_dat;
          r_rresp <= w_ld_resp;
        end
      end
    end
  end

  always_ff @(posedge clk_16M) begin
    if (w_w_hs && w_beat_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (expl_axi_wstrb[b]) r_mem[word_idx(r_addr)][8*b +: 8] <= expl_axi_wdata[8*b +: 8];
      end
    end
  end
endmodule
